// File: rtl/pgm_rom_port.sv
// 68000 responder for the BIOS/P-ROM region: one 64-bit line buffer, misses go to the SDRAM arbiter over a toggle req/ack link.
// Optional hit/miss counters are compiled in with PGM_ROM_PORT_STATS_EN.
module pgm_rom_port #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 21
) (
   input  logic              fixed_20m_clk,
   input  logic              reset,
   input  logic              cpu_as_n,
   input  logic              cpu_rw_n,
   input  logic              cpu_uds_n,
   input  logic              cpu_lds_n,
   input  logic [23:1]       cpu_adr,
   input  logic              rom_sel,
   output logic              cpu_dtack_n,
   output logic [15:0]       cpu_dout,
   input  logic              flush,
   output logic              arb_req_tgl,
   output logic [ADDR_W-1:0] arb_addr,
   input  logic              arb_ack_tgl,
   input  logic [63:0]       arb_data,
   output logic              busy
`ifdef PGM_ROM_PORT_STATS_EN
   ,
   output logic [15:0]       stat_hits,
   output logic [15:0]       stat_misses
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

   state_t                 r_state, w_state_nxt;
   logic                   r_cyc_d, r_start;
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic                   r_ack_seen;
   logic [63:0]            r_line;
   logic [ADDR_W-1:0]      r_line_tag;
   logic                   r_line_valid, r_flush_pend;
   logic                   r_dtack_n, r_req_tgl, r_busy;
   logic [15:0]            r_dout;
   logic [ADDR_W-1:0]      r_arb_addr;

   logic                   w_cyc, w_hit, w_ack_sync, w_ack_new;
   logic                   w_take, w_issue, w_fill, w_ack, w_release;
   logic [ADDR_W-1:0]      w_tag;
   logic [15:0]            w_word;

   assign cpu_dtack_n = r_dtack_n;
   assign cpu_dout    = r_dout;
   assign arb_req_tgl = r_req_tgl;
   assign arb_addr    = r_arb_addr;
   assign busy        = r_busy;

   always_comb begin
      w_cyc      = !cpu_as_n && rom_sel && (!cpu_uds_n || !cpu_lds_n);
      w_tag      = ADDR_W'(cpu_adr[23:3]);
      // a flush in the same cycle as the lookup forces a miss
      w_hit      = r_line_valid && !flush && (r_line_tag == w_tag);
      w_ack_sync = r_ack_sync[SYNC_STAGES-1];
      w_ack_new  = (w_ack_sync != r_ack_seen);
      case (cpu_adr[2:1])
         2'd0:    w_word = r_line[15:0];
         2'd1:    w_word = r_line[31:16];
         2'd2:    w_word = r_line[47:32];
         default: w_word = r_line[63:48];
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_issue     = 1'b0;
      w_fill      = 1'b0;
      w_ack       = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_start) begin
               w_take = 1'b1;
               if (!cpu_rw_n || w_hit) begin
                  w_state_nxt = S_ACK;
               end else begin
                  w_issue     = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (w_ack_new) begin
               w_fill      = 1'b1;
               w_state_nxt = w_cyc ? S_ACK : S_IDLE;
            end
         end
         S_ACK: begin
            w_ack       = 1'b1;
            w_state_nxt = S_HOLD;
         end
         default: begin
            if (cpu_as_n || !rom_sel) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge fixed_20m_clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cyc_d      <= 1'b0;
         r_start      <= 1'b0;
         r_ack_sync   <= '0;
         r_ack_seen   <= 1'b0;
         r_line       <= '0;
         r_line_tag   <= '0;
         r_line_valid <= 1'b0;
         r_flush_pend <= 1'b0;
         r_dtack_n    <= 1'b1;
         r_dout       <= '0;
         r_req_tgl    <= 1'b0;
         r_arb_addr   <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cyc_d    <= w_cyc;
         // start request stays pending while the cycle is active, so a restart during WAIT is not lost
         r_start    <= (r_start || (w_cyc && !r_cyc_d)) && w_cyc && !w_take;
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], arb_ack_tgl};

         if (w_issue) begin
            r_arb_addr <= w_tag;
            r_req_tgl  <= ~r_req_tgl;
            r_busy     <= 1'b1;
         end

         if (w_fill) begin
            r_line       <= arb_data;
            r_line_tag   <= r_arb_addr;
            r_ack_seen   <= w_ack_sync;
            r_busy       <= 1'b0;
            r_flush_pend <= 1'b0;
         end else if (r_state == S_WAIT && flush) begin
            r_flush_pend <= 1'b1;
         end

         if (flush) begin
            r_line_valid <= 1'b0;
         end else if (w_fill) begin
            r_line_valid <= !r_flush_pend;
         end

         if (w_ack) begin
            r_dtack_n <= 1'b0;
            r_dout    <= cpu_rw_n ? w_word : 16'h0000;
         end else if (w_release) begin
            r_dtack_n <= 1'b1;
            r_dout    <= '0;
         end
      end
   end

`ifdef PGM_ROM_PORT_STATS_EN
   logic [15:0] r_stat_hits, r_stat_misses;

   assign stat_hits   = r_stat_hits;
   assign stat_misses = r_stat_misses;

   always_ff @(posedge fixed_20m_clk) begin
      if (reset) begin
         r_stat_hits   <= '0;
         r_stat_misses <= '0;
      end else if (w_take && cpu_rw_n) begin
         if (w_hit) begin
            if (r_stat_hits != '1) r_stat_hits <= r_stat_hits + 16'd1;
         end else begin
            if (r_stat_misses != '1) r_stat_misses <= r_stat_misses + 16'd1;
         end
      end
   end
`endif

endmodule
